spi_bitrev_slave: RTL and testbench

Parametrised SPI slave test peripheral: it receives a DATA_W-bit word on MOSI and returns that word bit-reversed on MISO during the next DATA_W SCK cycles. Compared with the single-mode, SCK-clocked bit-reverse slave, it adds:
- all four SPI modes;
- a configurable frame width;
- back-to-back frames within one SS assertion;
- a receive-side strobe for the SoC.

All SPI pins are oversampled in the system clock domain, so the block uses a single clock. It sits on the SoC SPI master's slave-select line as a loopback target for driver and controller tests.

---
 rtl/spi_bitrev_pkg.sv | 17 +
 rtl/spi_pin_sync.sv | 43 ++++
 rtl/spi_bitrev_slave.sv | 147 ++++++++++++++
 tb/tb_spi_bitrev_slave.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_bitrev_pkg.sv
// Shared types, constants and helpers for the bit-reversing SPI slave.
package spi_bitrev_pkg;

    typedef enum logic [1:0] {IDLE, RX, TX, DONE} state_t;

    localparam int SYNC_DEPTH = 2;

    // Reverses the low `width` bits of value; the result sits in the low `width` bits.
    function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int width);
        logic [31:0] rev;
        for (int i = 0; i < 32; i++) begin
            rev[i] = value[31 - i];
        end
        return rev >> (32 - width);
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes {ss, sck, mosi} into the system clock domain and flags sck rise/fall.
module spi_pin_sync
    import spi_bitrev_pkg::*;
#(
    parameter logic [2:0] RST_VAL = 3'b100
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] pins,
    output logic       ss_s,
    output logic       mosi_s,
    output logic       sck_rise,
    output logic       sck_fall
);

    logic [2:0] stage [SYNC_DEPTH];
    logic       sck_s;
    logic       sck_prev;

    // NOTE: the synchronizer stages are reset to the idle pin levels so that
    // leaving reset never produces a phantom SCK edge or SS assertion.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_DEPTH; i++) begin
                stage[i] <= RST_VAL;
            end
            sck_prev <= RST_VAL[1];
        end else begin
            stage[0] <= pins;
            for (int i = 1; i < SYNC_DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
            sck_prev <= stage[SYNC_DEPTH-1][1];
        end
    end

    assign ss_s     = stage[SYNC_DEPTH-1][2];
    assign sck_s    = stage[SYNC_DEPTH-1][1];
    assign mosi_s   = stage[SYNC_DEPTH-1][0];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;

endmodule

// File: rtl/spi_bitrev_slave.sv
// SPI slave loopback target: receives a DATA_W-bit word and returns it bit-reversed in the next frame.
// Frame/abort statistics ports are built only when SPI_BITREV_SLAVE_STATS_EN is defined.
module spi_bitrev_slave
    import spi_bitrev_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0,
    parameter int CONTINUOUS = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              sck,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid
`ifdef SPI_BITREV_SLAVE_STATS_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        abort_cnt
`endif
);

    localparam logic [2:0] PIN_RST  = {1'b1, (CPOL != 0), 1'b0};
    localparam logic [4:0] LAST_BIT = 5'(DATA_W - 1);

    logic              ss_s;
    logic              mosi_s;
    logic              sck_rise;
    logic              sck_fall;
    logic              leading_edge;
    logic              trailing_edge;
    logic              sample_edge;
    logic              drive_edge;
    state_t            state;
    logic [4:0]        cnt;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_word;

    spi_pin_sync #(
        .RST_VAL (PIN_RST)
    ) u_sync (
        .clock    (clock),
        .reset_n  (reset_n),
        .pins     ({ss, sck, mosi}),
        .ss_s     (ss_s),
        .mosi_s   (mosi_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall)
    );

    assign leading_edge  = (CPOL != 0) ? sck_fall : sck_rise;
    assign trailing_edge = (CPOL != 0) ? sck_rise : sck_fall;
    assign sample_edge   = (CPHA != 0) ? trailing_edge : leading_edge;
    assign drive_edge    = (CPHA != 0) ? leading_edge : trailing_edge;
    assign rx_word       = {rx_sr[DATA_W-2:0], mosi_s};

    // NOTE: non-blocking assignments only, so every branch below sees the
    // pre-edge values of state, cnt and the shift registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rx_sr    <= '0;
            tx_sr    <= '0;
            miso     <= 1'b1;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (ss_s) begin
                // Deselect wins over any edge in the same cycle; rx_data is kept.
                state <= IDLE;
                cnt   <= '0;
                rx_sr <= '0;
                tx_sr <= '0;
                miso  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        state <= RX;
                        cnt   <= '0;
                        miso  <= 1'b1;
                    end
                    RX: begin
                        if (drive_edge) begin
                            miso <= 1'b1;
                        end
                        if (sample_edge) begin
                            rx_sr <= rx_word;
                            if (cnt == LAST_BIT) begin
                                tx_sr    <= DATA_W'(bit_reverse(32'(rx_word), DATA_W));
                                rx_data  <= rx_word;
                                rx_valid <= 1'b1;
                                state    <= TX;
                                cnt      <= '0;
                            end else begin
                                cnt <= cnt + 5'd1;
                            end
                        end
                    end
                    TX: begin
                        if (drive_edge) begin
                            miso  <= tx_sr[DATA_W-1];
                            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                        end
                        if (sample_edge) begin
                            if (cnt == LAST_BIT) begin
                                state <= (CONTINUOUS != 0) ? RX : DONE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 5'd1;
                            end
                        end
                    end
                    DONE: begin
                        miso <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef SPI_BITREV_SLAVE_STATS_EN
    // An abort is a deselect that cuts a frame short: mid-RX or anywhere in TX.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
            abort_cnt <= '0;
        end else begin
            if (rx_valid) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (ss_s && ((state == RX && cnt != '0) || state == TX) && abort_cnt != 8'hFF) begin
                abort_cnt <= abort_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_bitrev_slave.sv
// Self-checking bench: three slave configurations driven by a behavioural SPI master and frame model.
module tb_spi_bitrev_slave;

    localparam int H = 8;  // SCK half-period in system clocks
    localparam int W_OF    [3] = '{8, 8, 16};
    localparam int CPOL_OF [3] = '{0, 1, 0};
    localparam int CPHA_OF [3] = '{0, 1, 1};
    localparam int CONT_OF [3] = '{1, 0, 1};

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  sck_v = 3'b010;
    logic [2:0]  ss_v = 3'b111;
    logic [2:0]  mosi_v = 3'b000;
    logic        miso0, miso1, miso2;
    logic        valid0, valid1, valid2;
    logic [7:0]  rxd0, rxd1;
    logic [15:0] rxd2;
`ifdef SPI_BITREV_SLAVE_STATS_EN
    logic [15:0] frame_cnt0, frame_cnt1, frame_cnt2;
    logic [7:0]  abort_cnt0, abort_cnt1, abort_cnt2;
`endif

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] tx_q[$];
    logic [31:0] got_q[$];
    logic [31:0] exp_q0[$], exp_q1[$], exp_q2[$];

    always #5 clock = ~clock;

    spi_bitrev_slave #(.DATA_W(8), .CPOL(0), .CPHA(0), .CONTINUOUS(1)) u_mode0 (
        .clock(clock), .reset_n(reset_n), .sck(sck_v[0]), .ss(ss_v[0]), .mosi(mosi_v[0]),
        .miso(miso0), .rx_data(rxd0), .rx_valid(valid0)
`ifdef SPI_BITREV_SLAVE_STATS_EN
        , .frame_cnt(frame_cnt0), .abort_cnt(abort_cnt0)
`endif
    );

    spi_bitrev_slave #(.DATA_W(8), .CPOL(1), .CPHA(1), .CONTINUOUS(0)) u_mode3 (
        .clock(clock), .reset_n(reset_n), .sck(sck_v[1]), .ss(ss_v[1]), .mosi(mosi_v[1]),
        .miso(miso1), .rx_data(rxd1), .rx_valid(valid1)
`ifdef SPI_BITREV_SLAVE_STATS_EN
        , .frame_cnt(frame_cnt1), .abort_cnt(abort_cnt1)
`endif
    );

    spi_bitrev_slave #(.DATA_W(16), .CPOL(0), .CPHA(1), .CONTINUOUS(1)) u_mode1 (
        .clock(clock), .reset_n(reset_n), .sck(sck_v[2]), .ss(ss_v[2]), .mosi(mosi_v[2]),
        .miso(miso2), .rx_data(rxd2), .rx_valid(valid2)
`ifdef SPI_BITREV_SLAVE_STATS_EN
        , .frame_cnt(frame_cnt2), .abort_cnt(abort_cnt2)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic get_miso(input int sel);
        case (sel)
            0: return miso0;
            1: return miso1;
            default: return miso2;
        endcase
    endfunction

    function automatic logic get_valid(input int sel);
        case (sel)
            0: return valid0;
            1: return valid1;
            default: return valid2;
        endcase
    endfunction

    function automatic logic [31:0] get_rxd(input int sel);
        case (sel)
            0: return {24'h0, rxd0};
            1: return {24'h0, rxd1};
            default: return {16'h0, rxd2};
        endcase
    endfunction

    // Model: the response word is the received word read back to front.
    function automatic logic [31:0] rev_bits(input logic [31:0] v, input int w);
        logic [31:0] r = '0;
        for (int i = 0; i < w; i++) begin
            r[w-1-i] = v[i];
        end
        return r;
    endfunction

    function automatic logic [31:0] ones(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    endfunction

    task automatic push_exp(input int sel, input logic [31:0] val);
        case (sel)
            0: exp_q0.push_back(val);
            1: exp_q1.push_back(val);
            default: exp_q2.push_back(val);
        endcase
    endtask

    task automatic pop_exp(input int sel, output logic ok, output logic [31:0] val);
        ok = 1'b0;
        val = '0;
        case (sel)
            0: if (exp_q0.size() > 0) begin ok = 1'b1; val = exp_q0.pop_front(); end
            1: if (exp_q1.size() > 0) begin ok = 1'b1; val = exp_q1.pop_front(); end
            default: if (exp_q2.size() > 0) begin ok = 1'b1; val = exp_q2.pop_front(); end
        endcase
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    // One frame as the master sees it; nbits < DATA_W gives a truncated frame.
    task automatic spi_frame(input int sel, input int nbits, input logic [31:0] tx,
                             input logic [31:0] exp, output logic [31:0] got);
        int  w    = W_OF[sel];
        logic cpol = (CPOL_OF[sel] != 0);
        got = '0;
        for (int i = w - 1; i >= w - nbits; i--) begin
            if (CPHA_OF[sel] == 0) begin
                mosi_v[sel] = tx[i];
                wait_clk(H);
                got[i] = get_miso(sel);
                sck_v[sel] = ~cpol;
                wait_clk(H);
                sck_v[sel] = cpol;
            end else begin
                sck_v[sel] = ~cpol;
                mosi_v[sel] = tx[i];
                wait_clk(H);
                got[i] = get_miso(sel);
                sck_v[sel] = cpol;
                wait_clk(H);
            end
            check($sformatf("miso_dut%0d_bit%0d", sel, i), {31'h0, got[i]}, {31'h0, exp[i]});
        end
    endtask

    // Sends tx_q as consecutive frames in one SS assertion; results land in got_q.
    task automatic run_session(input int sel, input int last_bits);
        logic [31:0] exp, got;
        int  w = W_OF[sel];
        int  nb;
        bit  rx_frame, live;
        got_q.delete();
        ss_v[sel] = 1'b0;
        wait_clk(8);
        for (int k = 0; k < tx_q.size(); k++) begin
            nb = (k == tx_q.size() - 1 && last_bits > 0) ? last_bits : w;
            if (CONT_OF[sel] != 0) begin
                rx_frame = (k % 2 == 0);
                live = 1'b1;
            end else begin
                rx_frame = (k == 0);
                live = (k < 2);
            end
            exp = (!live || rx_frame) ? ones(w) : rev_bits(tx_q[k-1], w);
            if (live && rx_frame && nb == w) begin
                push_exp(sel, tx_q[k] & ones(w));
            end
            spi_frame(sel, nb, tx_q[k], exp, got);
            got_q.push_back(got);
        end
        wait_clk(H);
        ss_v[sel] = 1'b1;
        mosi_v[sel] = 1'b0;
        wait_clk(12);
    endtask

    // Compare process: every rx_valid must carry the model's next word, and
    // rx_data may only move together with rx_valid.
    logic [31:0] last_rxd [3];
    logic [31:0] cmp_exp;
    logic        cmp_ok;
    always @(negedge clock) begin
        for (int s = 0; s < 3; s++) begin
            if (!reset_n) begin
                last_rxd[s] = get_rxd(s);
            end else if (get_valid(s) || get_rxd(s) != last_rxd[s]) begin
                if (!get_valid(s)) begin
                    check($sformatf("rxd_without_valid_dut%0d", s), get_rxd(s), last_rxd[s]);
                end else begin
                    pop_exp(s, cmp_ok, cmp_exp);
                    if (!cmp_ok) begin
                        check($sformatf("unexpected_rx_valid_dut%0d", s), 32'h1, 32'h0);
                    end else begin
                        check($sformatf("rx_data_dut%0d", s), get_rxd(s), cmp_exp);
                    end
                end
                last_rxd[s] = get_rxd(s);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got;

        wait_clk(5);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset_miso_dut%0d", s), {31'h0, get_miso(s)}, 32'h1);
            check($sformatf("reset_rx_data_dut%0d", s), get_rxd(s), 32'h0);
            check($sformatf("reset_rx_valid_dut%0d", s), {31'h0, get_valid(s)}, 32'h0);
        end
        reset_n = 1'b1;
        wait_clk(10);

        // Mode 0, 8 bits: 0x13 then dummy clocks.
        tx_q = '{32'h13, 32'h00};
        run_session(0, 0);
        check("mode0_rx_phase_miso", got_q[0], 32'hFF);
        check("mode0_response", got_q[1], 32'hC8);
        check("mode0_rx_data", get_rxd(0), 32'h13);

        // Mode 3, non-continuous: second word gets no response and no rx_valid.
        tx_q = '{32'hF0, 32'h00, 32'h80, 32'h00};
        run_session(1, 0);
        check("mode3_rx_phase_miso", got_q[0], 32'hFF);
        check("mode3_response", got_q[1], 32'h0F);
        check("mode3_done_word_miso", got_q[2], 32'hFF);
        check("mode3_done_dummy_miso", got_q[3], 32'hFF);
        check("mode3_rx_data_held", get_rxd(1), 32'hF0);

        // Mode 1, 16 bits.
        tx_q = '{32'h1234, 32'h0000};
        run_session(2, 0);
        check("mode1_w16_response", got_q[1], 32'h2C48);
        check("mode1_w16_rx_data", get_rxd(2), 32'h1234);

        // Continuous: two word/response pairs in one SS assertion.
        tx_q = '{32'h01, 32'h00, 32'h80, 32'h00};
        run_session(0, 0);
        check("cont_first_response", got_q[1], 32'h80);
        check("cont_second_response", got_q[3], 32'h01);
        check("cont_rx_data", get_rxd(0), 32'h80);

        // Abort after 5 bits, then a full frame.
        tx_q = '{32'hB5};
        run_session(0, 5);
        tx_q = '{32'h01, 32'h00};
        run_session(0, 0);
        check("abort_then_response", got_q[1], 32'h80);
        check("abort_then_rx_data", get_rxd(0), 32'h01);
`ifdef SPI_BITREV_SLAVE_STATS_EN
        check("abort_cnt", {24'h0, abort_cnt0}, 32'h1);
`endif

        // Reset mid-TX: the next TX bit on miso is 0, so reset must force it high.
        ss_v[0] = 1'b0;
        wait_clk(8);
        push_exp(0, 32'h0F);
        spi_frame(0, 8, 32'h0F, 32'hFF, got);
        spi_frame(0, 4, 32'h00, rev_bits(32'h0F, 8), got);
        wait_clk(6);
        reset_n = 1'b0;
        #1;
        check("midtx_reset_miso", {31'h0, miso0}, 32'h1);
        check("midtx_reset_rx_data", get_rxd(0), 32'h0);
        check("midtx_reset_rx_valid", {31'h0, valid0}, 32'h0);
        ss_v[0] = 1'b1;
        mosi_v[0] = 1'b0;
        sck_v[0] = 1'b0;
        wait_clk(4);
        reset_n = 1'b1;
        wait_clk(10);
        tx_q = '{32'hA0, 32'h00};
        run_session(0, 0);
        check("post_reset_response", got_q[1], 32'h05);
        check("post_reset_rx_data", get_rxd(0), 32'hA0);

        wait_clk(10);
        check("exp_q0_drained", exp_q0.size(), 32'h0);
        check("exp_q1_drained", exp_q1.size(), 32'h0);
        check("exp_q2_drained", exp_q2.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
